// File: rtl/zap_shift_pipe_if.sv
// Issue/result bundle for the pipelined shifter.
// The master drives an operation in and receives the shifted result back.
interface zap_shift_pipe_if #(
  parameter int DATA_WD = 32,
  parameter int AMT_WD  = 8,
  parameter int TAG_WD  = 6
);
  logic               i_valid;
  logic [DATA_WD-1:0] i_source;
  logic [AMT_WD-1:0]  i_amount;
  logic [2:0]         i_shift_type;
  logic               i_carry;
  logic [TAG_WD-1:0]  i_tag;
  logic               i_stall;
  logic               i_flush;
  logic               o_valid;
  logic [DATA_WD-1:0] o_result;
  logic               o_carry;
  logic               o_rrx;
  logic [TAG_WD-1:0]  o_tag;
  logic               o_illegal;

  modport master (
    output i_valid, i_source, i_amount, i_shift_type, i_carry, i_tag, i_stall, i_flush,
    input  o_valid, o_result, o_carry, o_rrx, o_tag, o_illegal
  );

  modport slave (
    input  i_valid, i_source, i_amount, i_shift_type, i_carry, i_tag, i_stall, i_flush,
    output o_valid, o_result, o_carry, o_rrx, o_tag, o_illegal
  );
endinterface

// File: rtl/zap_shift_pipe.sv
// Pipelined ARM barrel shifter (LSL/LSR/ASR/ROR/RORI + internal RRX).
// log2(W) power-of-two mux levels followed by one fix-up level that applies
// the zero-amount and out-of-range rules; levels are spread over the stages
// with earlier stages taking the extra ones.
module zap_shift_pipe #(
  parameter int DATA_WD     = 32,
  parameter int AMT_WD      = 8,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WD      = 6
) (
  input  logic            i_clk,
  input  logic            i_reset,
  zap_shift_pipe_if.slave bus
);
  localparam int LOGW   = $clog2(DATA_WD);
  localparam int LEVELS = LOGW + 1;

  localparam logic [2:0] T_LSL  = 3'd0;
  localparam logic [2:0] T_LSR  = 3'd1;
  localparam logic [2:0] T_ASR  = 3'd2;
  localparam logic [2:0] T_ROR  = 3'd3;
  localparam logic [2:0] T_RORI = 3'd4;

  // carry holds the last bit shifted out so far; cin is the untouched CPSR C.
  typedef struct packed {
    logic               valid;
    logic [TAG_WD-1:0]  tag;
    logic [2:0]         typ;
    logic [LOGW-1:0]    amt;
    logic               amt_zero;
    logic               amt_eq_w;
    logic               amt_gt_w;
    logic               cin;
    logic               carry;
    logic               rrx;
    logic               ill;
    logic [DATA_WD-1:0] data;
  } stage_t;

  stage_t issue_d;
  stage_t stage_d [PIPE_STAGES];
  stage_t stage_q [PIPE_STAGES];

  // First level index handled by stage s (stage PIPE_STAGES returns LEVELS).
  function automatic int stage_lo(input int s);
    int base;
    int extra;
    base  = LEVELS / PIPE_STAGES;
    extra = LEVELS % PIPE_STAGES;
    return s * base + ((s < extra) ? s : extra);
  endfunction

  // One power-of-two shift level, tracking the last bit shifted out.
  function automatic stage_t shift_level(input stage_t st, input int k);
    stage_t             r;
    logic [LOGW-1:0]    amt_sh;
    logic [DATA_WD-1:0] out_bits;
    int                 sh;
    r        = st;
    sh       = 1 << k;
    amt_sh   = st.amt >> k;
    out_bits = '0;
    if (amt_sh[0]) begin
      case (st.typ)
        T_LSL: begin
          out_bits = st.data >> (DATA_WD - sh);
          r.carry  = out_bits[0];
          r.data   = st.data << sh;
        end
        T_LSR: begin
          out_bits = st.data >> (sh - 1);
          r.carry  = out_bits[0];
          r.data   = st.data >> sh;
        end
        T_ASR: begin
          out_bits = st.data >> (sh - 1);
          r.carry  = out_bits[0];
          r.data   = $unsigned($signed(st.data) >>> sh);
        end
        T_ROR, T_RORI: begin
          r.data = (st.data >> sh) | (st.data << (DATA_WD - sh));
        end
        default: begin
          r = st;
        end
      endcase
    end else begin
      r = st;
    end
    return r;
  endfunction

  // Final level: zero amount, amount == W, amount > W, RRX and reserved types.
  // For A == W the mux levels did nothing, so data still equals the source;
  // for ASR the sign bit survives every level, so data[W-1] is the source MSB.
  function automatic stage_t fix_up(input stage_t st);
    stage_t r;
    r = st;
    case (st.typ)
      T_LSL, T_LSR: begin
        if (st.amt_zero) begin
          r.carry = st.cin;
        end else if (st.amt_eq_w) begin
          r.carry = (st.typ == T_LSL) ? st.data[0] : st.data[DATA_WD-1];
          r.data  = '0;
        end else if (st.amt_gt_w) begin
          r.carry = 1'b0;
          r.data  = '0;
        end else begin
          r.carry = st.carry;
        end
      end
      T_ASR: begin
        if (st.amt_zero) begin
          r.carry = st.cin;
        end else if (st.amt_eq_w || st.amt_gt_w) begin
          r.carry = st.data[DATA_WD-1];
          r.data  = {DATA_WD{st.data[DATA_WD-1]}};
        end else begin
          r.carry = st.carry;
        end
      end
      T_ROR: begin
        if (st.amt_zero) begin
          r.carry = st.data[0];
          r.data  = {st.cin, st.data[DATA_WD-1:1]};
          r.rrx   = 1'b1;
        end else begin
          r.carry = st.data[DATA_WD-1];
        end
      end
      T_RORI: begin
        r.carry = st.amt_zero ? st.cin : st.data[DATA_WD-1];
      end
      default: begin
        r.carry = st.cin;
        r.ill   = 1'b1;
      end
    endcase
    return r;
  endfunction

  // Apply levels [lo, hi) to a stage payload.
  function automatic stage_t apply_levels(input stage_t st, input int lo, input int hi);
    stage_t r;
    r = st;
    for (int k = 0; k <= LOGW; k++) begin
      if (k >= lo && k < hi) begin
        if (k < LOGW) begin
          r = shift_level(r, k);
        end else begin
          r = fix_up(r);
        end
      end
    end
    return r;
  endfunction

  // Capture the incoming op and precompute its amount range flags.
  always_comb begin
    issue_d          = '0;
    issue_d.valid    = bus.i_valid;
    issue_d.tag      = bus.i_tag;
    issue_d.typ      = bus.i_shift_type;
    issue_d.amt      = bus.i_amount[LOGW-1:0];
    issue_d.amt_zero = (bus.i_amount == AMT_WD'(0));
    issue_d.amt_eq_w = (bus.i_amount == AMT_WD'(DATA_WD));
    issue_d.amt_gt_w = (bus.i_amount > AMT_WD'(DATA_WD));
    issue_d.cin      = bus.i_carry;
    issue_d.carry    = bus.i_carry;
    issue_d.data     = bus.i_source;
  end

  // Next-state of each stage: its share of the mux levels on the previous stage.
  always_comb begin
    stage_d[0] = apply_levels(issue_d, stage_lo(0), stage_lo(1));
    for (int s = 1; s < PIPE_STAGES; s++) begin
      stage_d[s] = apply_levels(stage_q[s-1], stage_lo(s), stage_lo(s + 1));
    end
  end

  // Stage registers: flush beats stall; bubbles advance without touching data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else if (bus.i_flush) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        stage_q[s].valid <= 1'b0;
      end
    end else if (!bus.i_stall) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (stage_d[s].valid) begin
          stage_q[s] <= stage_d[s];
        end else begin
          stage_q[s].valid <= 1'b0;
        end
      end
    end
  end

  assign bus.o_valid   = stage_q[PIPE_STAGES-1].valid;
  assign bus.o_result  = stage_q[PIPE_STAGES-1].data;
  assign bus.o_carry   = stage_q[PIPE_STAGES-1].carry;
  assign bus.o_tag     = stage_q[PIPE_STAGES-1].tag;
  assign bus.o_rrx     = stage_q[PIPE_STAGES-1].valid & stage_q[PIPE_STAGES-1].rrx;
  assign bus.o_illegal = stage_q[PIPE_STAGES-1].valid & stage_q[PIPE_STAGES-1].ill;
endmodule

// File: tb/tb_zap_shift_pipe.sv
// Bench for zap_shift_pipe: three configurations (W32/P2, W32/P1, W64/P5)
// driven with the same stimulus, compared every cycle against a latency
// delay line filled by an arithmetic model of the ARM shift rules.
module tb_zap_shift_pipe;
  typedef struct packed {
    logic        v;
    logic [63:0] res;
    logic        c;
    logic        rrx;
    logic        ill;
    logic [5:0]  tag;
  } exp_t;

  typedef struct packed {
    logic [63:0] s;
    logic [7:0]  a;
    logic [2:0]  t;
    logic        c;
  } vec_t;

  localparam int P_OF [3] = '{2, 1, 5};
  localparam int W_OF [3] = '{32, 32, 64};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v = 1'b0, cin = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [63:0] src = 64'd0;
  logic [7:0]  amt = 8'd0;
  logic [2:0]  typ = 3'd0;
  logic [5:0]  tag = 6'd0, tag_n = 6'd0;
  int          n_cmp = 0, n_bad = 0, v0_cnt = 0;
  exp_t        line [3][6];

  zap_shift_pipe_if #(.DATA_WD(32), .AMT_WD(8), .TAG_WD(6)) bus0 ();
  zap_shift_pipe_if #(.DATA_WD(32), .AMT_WD(8), .TAG_WD(6)) bus1 ();
  zap_shift_pipe_if #(.DATA_WD(64), .AMT_WD(8), .TAG_WD(6)) bus2 ();

  zap_shift_pipe #(.DATA_WD(32), .AMT_WD(8), .PIPE_STAGES(2), .TAG_WD(6))
    dut0 (.i_clk(clk), .i_reset(rst), .bus(bus0));
  zap_shift_pipe #(.DATA_WD(32), .AMT_WD(8), .PIPE_STAGES(1), .TAG_WD(6))
    dut1 (.i_clk(clk), .i_reset(rst), .bus(bus1));
  zap_shift_pipe #(.DATA_WD(64), .AMT_WD(8), .PIPE_STAGES(5), .TAG_WD(6))
    dut2 (.i_clk(clk), .i_reset(rst), .bus(bus2));

  assign bus0.i_valid = v;  assign bus0.i_source = src[31:0]; assign bus0.i_amount = amt;
  assign bus0.i_shift_type = typ; assign bus0.i_carry = cin; assign bus0.i_tag = tag;
  assign bus0.i_stall = stall; assign bus0.i_flush = flush;
  assign bus1.i_valid = v;  assign bus1.i_source = src[31:0]; assign bus1.i_amount = amt;
  assign bus1.i_shift_type = typ; assign bus1.i_carry = cin; assign bus1.i_tag = tag;
  assign bus1.i_stall = stall; assign bus1.i_flush = flush;
  assign bus2.i_valid = v;  assign bus2.i_source = src; assign bus2.i_amount = amt;
  assign bus2.i_shift_type = typ; assign bus2.i_carry = cin; assign bus2.i_tag = tag;
  assign bus2.i_stall = stall; assign bus2.i_flush = flush;

  always #5 clk = ~clk;

  function automatic logic bit_at(input logic [63:0] x, input int i);
    logic [63:0] t;
    t = x >> i;
    return t[0];
  endfunction

  // Direct statement of the shift rules on a w-bit value held in 64 bits.
  function automatic exp_t model(input int w, input logic [63:0] s_in, input logic [7:0] a8,
                                 input logic [2:0] t, input logic ci, input logic [5:0] g,
                                 input logic vv);
    exp_t e;
    logic [63:0] mask, s, rot;
    logic msb;
    int a, r;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    s    = s_in & mask;
    a    = int'(a8);
    r    = a % w;
    rot  = (r == 0) ? s : (((s >> r) | (s << (w - r))) & mask);
    msb  = bit_at(s, w - 1);
    e.v = vv; e.tag = g; e.res = s; e.c = ci; e.rrx = 1'b0; e.ill = 1'b0;
    case (t)
      3'd0: if (a == 0) e.c = ci;
            else if (a < w) begin e.res = (s << a) & mask; e.c = bit_at(s, w - a); end
            else if (a == w) begin e.res = 64'd0; e.c = bit_at(s, 0); end
            else begin e.res = 64'd0; e.c = 1'b0; end
      3'd1: if (a == 0) e.c = ci;
            else if (a < w) begin e.res = s >> a; e.c = bit_at(s, a - 1); end
            else if (a == w) begin e.res = 64'd0; e.c = msb; end
            else begin e.res = 64'd0; e.c = 1'b0; end
      3'd2: if (a == 0) e.c = ci;
            else if (a < w) begin
              e.res = (s >> a) | (msb ? (mask & ~(mask >> a)) : 64'd0);
              e.c   = bit_at(s, a - 1);
            end else begin e.res = msb ? mask : 64'd0; e.c = msb; end
      3'd3: if (a == 0) begin
              e.res = (s >> 1) | ({63'd0, ci} << (w - 1));
              e.c = bit_at(s, 0); e.rrx = 1'b1;
            end else begin e.res = rot; e.c = bit_at(rot, w - 1); end
      3'd4: if (a == 0) e.c = ci;
            else begin e.res = rot; e.c = bit_at(rot, w - 1); end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pin(input string name, input exp_t e, input logic [63:0] res,
                     input logic c, input logic rrx, input logic ill);
    chk({name, " result"}, e.res, res);
    chk({name, " c/rrx/ill"}, {61'd0, e.c, e.rrx, e.ill}, {61'd0, c, rrx, ill});
  endtask

  task automatic check_dut(input int d, input logic av, input logic [63:0] ares, input logic ac,
                           input logic arrx, input logic aill, input logic [5:0] atag);
    exp_t e;
    e = line[d][P_OF[d] - 1];
    if (rst) begin
      chk($sformatf("dut%0d reset valid", d), {63'd0, av}, 64'd0);
      chk($sformatf("dut%0d reset result", d), ares, 64'd0);
      chk($sformatf("dut%0d reset flags", d), {55'd0, ac, arrx, aill, atag}, 64'd0);
    end else begin
      chk($sformatf("dut%0d valid", d), {63'd0, av}, {63'd0, e.v});
      if (e.v) begin
        chk($sformatf("dut%0d result tag%0d", d, e.tag), ares, e.res);
        chk($sformatf("dut%0d c/rrx/ill tag%0d", d, e.tag), {61'd0, ac, arrx, aill},
            {61'd0, e.c, e.rrx, e.ill});
        chk($sformatf("dut%0d tag", d), {58'd0, atag}, {58'd0, e.tag});
      end else begin
        chk($sformatf("dut%0d idle rrx/ill", d), {62'd0, arrx, aill}, 64'd0);
      end
    end
  endtask

  // Latency delay line: reset > flush > stall, one slot per register stage.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) for (int s = 0; s < 6; s++) line[d][s].v <= 1'b0;
    end else if (flush) begin
      for (int d = 0; d < 3; d++) for (int s = 0; s < 6; s++) line[d][s].v <= 1'b0;
    end else if (!stall) begin
      for (int d = 0; d < 3; d++) begin
        for (int s = 1; s < 6; s++) line[d][s] <= line[d][s-1];
        line[d][0] <= model(W_OF[d], src, amt, typ, cin, tag, v);
      end
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    check_dut(0, bus0.o_valid, {32'd0, bus0.o_result}, bus0.o_carry, bus0.o_rrx,
              bus0.o_illegal, bus0.o_tag);
    check_dut(1, bus1.o_valid, {32'd0, bus1.o_result}, bus1.o_carry, bus1.o_rrx,
              bus1.o_illegal, bus1.o_tag);
    check_dut(2, bus2.o_valid, bus2.o_result, bus2.o_carry, bus2.o_rrx,
              bus2.o_illegal, bus2.o_tag);
    if (bus0.o_valid === 1'b1) v0_cnt++;
  end

  task automatic step(input logic vv, input logic [63:0] ss, input logic [7:0] aa,
                      input logic [2:0] tt, input logic cc, input logic st, input logic fl);
    v = vv; src = ss; amt = aa; typ = tt; cin = cc; stall = st; flush = fl; tag = tag_n;
    if (vv) tag_n++;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t vecs [14] = '{
    '{64'h0000_0000_8000_0001, 8'd0,  3'd0, 1'b1},
    '{64'h0000_0000_8000_0001, 8'd32, 3'd0, 1'b1},
    '{64'h0000_0000_8000_0001, 8'd33, 3'd0, 1'b1},
    '{64'h0000_0000_8000_0001, 8'd32, 3'd1, 1'b1},
    '{64'h0000_0000_8000_0001, 8'd40, 3'd2, 1'b1},
    '{64'h0000_0000_0000_0003, 8'd0,  3'd3, 1'b1},
    '{64'h0000_0000_0000_0003, 8'd32, 3'd3, 1'b0},
    '{64'h0000_0000_0000_0003, 8'd1,  3'd3, 1'b0},
    '{64'h0000_0000_0000_0003, 8'd0,  3'd4, 1'b0},
    '{64'h0000_0000_0000_1234, 8'd0,  3'd6, 1'b0},
    '{64'hF000_0000_8000_0081, 8'd5,  3'd2, 1'b0},
    '{64'h8000_0000_8000_0001, 8'd64, 3'd1, 1'b1},
    '{64'h1234_5678_9ABC_DEF1, 8'd31, 3'd0, 1'b0},
    '{64'h1234_5678_9ABC_DEF1, 8'd36, 3'd4, 1'b1}
  };

  initial begin
    // Hand-computed values that pin the model to the ARM rules.
    pin("lsl0",  model(32, 64'h8000_0001, 8'd0,  3'd0, 1'b1, 6'd0, 1'b1), 64'h8000_0001, 1'b1, 1'b0, 1'b0);
    pin("lsl32", model(32, 64'h8000_0001, 8'd32, 3'd0, 1'b1, 6'd0, 1'b1), 64'd0, 1'b1, 1'b0, 1'b0);
    pin("lsl33", model(32, 64'h8000_0001, 8'd33, 3'd0, 1'b1, 6'd0, 1'b1), 64'd0, 1'b0, 1'b0, 1'b0);
    pin("lsr32", model(32, 64'h8000_0001, 8'd32, 3'd1, 1'b1, 6'd0, 1'b1), 64'd0, 1'b1, 1'b0, 1'b0);
    pin("asr40", model(32, 64'h8000_0001, 8'd40, 3'd2, 1'b1, 6'd0, 1'b1), 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    pin("rrx",   model(32, 64'h3, 8'd0,  3'd3, 1'b1, 6'd0, 1'b1), 64'h8000_0001, 1'b1, 1'b1, 1'b0);
    pin("ror32", model(32, 64'h3, 8'd32, 3'd3, 1'b0, 6'd0, 1'b1), 64'h3, 1'b0, 1'b0, 1'b0);
    pin("ror1",  model(32, 64'h3, 8'd1,  3'd3, 1'b0, 6'd0, 1'b1), 64'h8000_0001, 1'b1, 1'b0, 1'b0);
    pin("rori0", model(32, 64'h3, 8'd0,  3'd4, 1'b0, 6'd0, 1'b1), 64'h3, 1'b0, 1'b0, 1'b0);
    pin("rsv6",  model(32, 64'h1234, 8'd0, 3'd6, 1'b0, 6'd0, 1'b1), 64'h1234, 1'b0, 1'b0, 1'b1);
    pin("rsv6w64", model(64, 64'h1234, 8'd0, 3'd6, 1'b0, 6'd0, 1'b1), 64'h1234, 1'b0, 1'b0, 1'b1);
    pin("lsl32w64", model(64, 64'h8000_0001, 8'd32, 3'd0, 1'b1, 6'd0, 1'b1),
        64'h8000_0001_0000_0000, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Directed amount-edge and rotate vectors back to back.
    foreach (vecs[i]) step(1'b1, vecs[i].s, vecs[i].a, vecs[i].t, vecs[i].c, 1'b0, 1'b0);
    idle(7);

    // Ten random ops on consecutive cycles.
    v0_cnt = 0;
    for (int i = 0; i < 10; i++)
      step(1'b1, {$urandom, $urandom}, 8'($urandom_range(0, 70)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'b0, 1'b0);
    idle(7);
    chk("b2b valid count", 64'(v0_cnt), 64'd10);

    // Stall for three cycles mid-stream; stalled input must be ignored.
    for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, 8'(i * 9 + 1), 3'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'd3, 3'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, 8'(i * 11 + 2), 3'(i + 2), 1'b0, 1'b0, 1'b0);
    idle(7);

    // Flush with stall also asserted, then one op at normal latency.
    for (int i = 0; i < 2; i++) step(1'b1, 64'h0F0F_0000_F0F0_0001, 8'(i + 4), 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h5555_AAAA_5555_AAAA, 8'd7, 3'd3, 1'b1, 1'b1, 1'b1);
    chk("flush dut0 valid", {63'd0, bus0.o_valid}, 64'd0);
    chk("flush dut2 valid", {63'd0, bus2.o_valid}, 64'd0);
    step(1'b1, 64'h0000_0000_8000_0001, 8'd1, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(7);

    // Reserved types.
    step(1'b1, 64'h1234, 8'd0, 3'd6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'hFFFF_0000_0000_1234, 8'd9, 3'd7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h1234, 8'd3, 3'd5, 1'b0, 1'b0, 1'b0);
    idle(7);

    // Asynchronous reset with two ops in flight.
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd4, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h8000_0000_8000_0000, 8'd2, 3'd2, 1'b1, 1'b0, 1'b0);
    v = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async rst dut0 valid", {63'd0, bus0.o_valid}, 64'd0);
    chk("async rst dut0 result", {32'd0, bus0.o_result}, 64'd0);
    chk("async rst dut2 valid", {63'd0, bus2.o_valid}, 64'd0);
    chk("async rst dut2 result", bus2.o_result, 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
